// File: rtl/mfp_vga_pkg.sv
// Shared types and sizes for the VGA frame-buffer arbiter.
package mfp_vga_pkg;

   localparam int unsigned ADDR_W   = 17;
   localparam int unsigned DATA_W   = 12;
   localparam int unsigned FB_DEPTH = 76800;

   // Owner of the RAM read data returning in a given cycle.
   typedef enum logic [1:0] {
      TAG_NONE,
      TAG_VID,
      TAG_CPU
   } tag_e;

   typedef enum logic [1:0] {
      C_IDLE,
      C_WAIT,
      C_RD,
      C_ACK
   } cpu_state_e;

endpackage

// File: rtl/mfp_vga_fb_arbiter_if.sv
// Scan-out, CPU and RAM signal bundle for the frame-buffer arbiter.
interface mfp_vga_fb_arbiter_if;
   import mfp_vga_pkg::*;

   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_valid;
   logic [DATA_W-1:0] vid_rdata;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_err;
   logic              cpu_starve;

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // Arbiter side.
   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
      output vid_valid, vid_rdata, cpu_ack, cpu_rdata, cpu_err, cpu_starve,
             ram_en, ram_we, ram_addr, ram_wdata
   );

   // Requester / RAM side.
   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
      input  vid_valid, vid_rdata, cpu_ack, cpu_rdata, cpu_err, cpu_starve,
             ram_en, ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/mfp_vga_fb_arbiter.sv
// Shares the single-port frame-buffer RAM between scan-out (fixed priority, fixed
// 2-cycle latency) and the CPU req/ack port, which fills the idle slots.
module mfp_vga_fb_arbiter
   import mfp_vga_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   mfp_vga_fb_arbiter_if.slave bus
);

   localparam int unsigned       CNT_W    = $clog2(MAX_WAIT + 2);
   localparam logic [CNT_W-1:0]  WAIT_SAT = CNT_W'(MAX_WAIT + 1);
   localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_DEPTH);

   cpu_state_e        state_q, state_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic              starve_q, starve_d;
   tag_e              tag0_q, tag1_q, cmd_tag;
   logic              en_q, we_q, cmd_en, cmd_we;
   logic [ADDR_W-1:0] addr_q, cmd_addr;
   logic [DATA_W-1:0] wdata_q, cmd_wdata;
   logic [DATA_W-1:0] crdata_q;
   logic              cpu_grant;
   logic              cpu_in_range;

   assign cpu_in_range = (bus.cpu_addr < FB_LIMIT);
   // Video always wins the slot; the CPU only gets edges where scan-out is quiet.
   assign cpu_grant    = (state_q == C_WAIT) && !bus.vid_req;

   // CPU handshake FSM next-state.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      unique case (state_q)
         C_IDLE: begin
            if (bus.cpu_req) begin
               state_d = cpu_in_range ? C_WAIT : C_ACK;
               err_d   = !cpu_in_range;
            end
         end
         C_WAIT: begin
            if (cpu_grant) state_d = bus.cpu_we ? C_ACK : C_RD;
         end
         C_RD:   state_d = C_ACK;
         C_ACK: begin
            state_d = C_IDLE;
            err_d   = 1'b0;
         end
         default: state_d = C_IDLE;
      endcase
   end

   // Wait counter saturates; starvation flag is sticky until reset.
   always_comb begin
      wait_d = '0;
      if (state_q == C_WAIT) wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + 1'b1;
      starve_d = starve_q | (wait_d == WAIT_SAT);
   end

   // RAM command selection for this edge; address/data hold when idle.
   always_comb begin
      cmd_en    = 1'b0;
      cmd_we    = 1'b0;
      cmd_addr  = addr_q;
      cmd_wdata = wdata_q;
      cmd_tag   = TAG_NONE;
      if (bus.vid_req) begin
         cmd_en   = 1'b1;
         cmd_addr = bus.vid_addr;
         cmd_tag  = TAG_VID;
      end else if (cpu_grant) begin
         cmd_en   = 1'b1;
         cmd_we   = bus.cpu_we;
         cmd_addr = bus.cpu_addr;
         if (bus.cpu_we) cmd_wdata = bus.cpu_wdata;
         else            cmd_tag   = TAG_CPU;
      end
   end

   // State, command and tag-pipe registers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= C_IDLE;
         err_q    <= 1'b0;
         wait_q   <= '0;
         starve_q <= 1'b0;
         en_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         tag0_q   <= TAG_NONE;
         tag1_q   <= TAG_NONE;
         crdata_q <= '0;
      end else begin
         state_q  <= state_d;
         err_q    <= err_d;
         wait_q   <= wait_d;
         starve_q <= starve_d;
         en_q     <= cmd_en;
         we_q     <= cmd_we;
         addr_q   <= cmd_addr;
         wdata_q  <= cmd_wdata;
         tag0_q   <= cmd_tag;
         tag1_q   <= tag0_q;
         if (tag1_q == TAG_CPU) crdata_q <= bus.ram_rdata;
      end
   end

   // Read data is passed straight through in the cycle its tag emerges.
   assign bus.vid_valid  = (tag1_q == TAG_VID);
   assign bus.vid_rdata  = (tag1_q == TAG_VID) ? bus.ram_rdata : '0;
   assign bus.cpu_rdata  = (tag1_q == TAG_CPU) ? bus.ram_rdata : crdata_q;
   assign bus.cpu_ack    = (state_q == C_ACK);
   assign bus.cpu_err    = (state_q == C_ACK) && err_q;
   assign bus.cpu_starve = starve_q;
   assign bus.ram_en     = en_q;
   assign bus.ram_we     = we_q;
   assign bus.ram_addr   = addr_q;
   assign bus.ram_wdata  = wdata_q;

endmodule
